// File: rtl/msp430_ram_master.sv
// msp430_ram_master
//   Single-outstanding request/response bridge onto a synchronous single-port
//   RAM with per-byte write enables and one cycle of read latency.
//
//   Ports
//     ram_clk, ram_rst   clock, synchronous active-high reset
//     req_*              request channel (valid/ready); byte address in req_addr
//     rsp_*              response channel (valid/ready); rsp_err on rejected access
//     ram_addr/din/cen/wen/dout
//                        RAM macro pins; cen and wen are active low
//
//   A legal request strobes the RAM combinationally in its handshake cycle.
//   Writes answer one cycle later; reads pass through RD, where ram_dout is
//   captured and byte lanes are selected. Illegal requests (out of range, or
//   a misaligned word access) never touch the RAM and answer with rsp_err.
module msp430_ram_master #(
  parameter int AW       = 6,
  parameter int DW       = 16,
  parameter int MEM_SIZE = 256
) (
  input  logic          ram_clk,
  input  logic          ram_rst,
  // request channel
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW:0]   req_addr,
  input  logic          req_we,
  input  logic          req_byte,
  input  logic [DW-1:0] req_wdata,
  // response channel
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  // RAM macro
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_cen,
  output logic [1:0]    ram_wen,
  input  logic [DW-1:0] ram_dout
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] RSP  = 2'd2;

  logic [1:0]  state;
  logic        hs;
  logic        addr_oob;
  logic        misalign;
  logic        illegal;
  logic        strobe;
  logic [31:0] addr_ext;

  // Byte-lane bookkeeping captured at handshake and consumed in RD.
  logic        rd_byte;
  logic        rd_hi;

  // ---------------------------------------------------------------------------
  // Request acceptance and legality
  // ---------------------------------------------------------------------------
  assign req_ready = (state == IDLE) && !ram_rst;
  assign hs        = req_valid && req_ready;

  // Widen before comparing so MEM_SIZE larger than the address space is safe.
  assign addr_ext  = 32'(req_addr);
  assign addr_oob  = addr_ext >= 32'(MEM_SIZE);
  assign misalign  = !req_byte && req_addr[0];
  assign illegal   = addr_oob || misalign;
  assign strobe    = hs && !illegal;

  // ---------------------------------------------------------------------------
  // RAM drive: idle values everywhere except a legal handshake cycle
  // ---------------------------------------------------------------------------
  always_comb begin
    ram_cen  = 1'b1;
    ram_wen  = 2'b11;
    ram_addr = '0;
    ram_din  = '0;
    if (strobe) begin
      ram_cen  = 1'b0;
      ram_addr = req_addr[AW:1];
      if (req_we) begin
        if (!req_byte) begin
          ram_wen = 2'b00;
          ram_din = req_wdata;
        end else if (req_addr[0]) begin
          // odd byte lives in the high half of the word
          ram_wen = 2'b01;
          ram_din = DW'({req_wdata[7:0], 8'h00});
        end else begin
          ram_wen = 2'b10;
          ram_din = DW'({8'h00, req_wdata[7:0]});
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM and response registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge ram_clk) begin
    if (ram_rst) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      rd_byte   <= 1'b0;
      rd_hi     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hs) begin
            if (illegal) begin
              state     <= RSP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else if (req_we) begin
              state     <= RSP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_rdata <= '0;
            end else begin
              state   <= RD;
              rd_byte <= req_byte;
              rd_hi   <= req_addr[0];
            end
          end
        end
        RD: begin
          // ram_dout is valid now, one cycle after the strobe
          state     <= RSP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          if (!rd_byte)
            rsp_rdata <= ram_dout;
          else if (rd_hi)
            rsp_rdata <= DW'(ram_dout[15:8]);
          else
            rsp_rdata <= DW'(ram_dout[7:0]);
        end
        RSP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_msp430_ram_master.sv
module tb_msp430_ram_master;

  localparam int AW = 6;
  localparam int DW = 16;
  localparam int MS = 64;

  logic          ram_clk = 1'b0;
  logic          ram_rst;
  logic          req_valid, req_ready, req_we, req_byte;
  logic [AW:0]   req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;
  logic          ram_cen;
  logic [1:0]    ram_wen;

  int errs   = 0;
  int checks = 0;

  // expected response {err, rdata}
  logic [16:0] sb[$];

  always #5 ram_clk = ~ram_clk;

  msp430_ram_master #(.AW(AW), .DW(DW), .MEM_SIZE(MS)) dut (
    .ram_clk(ram_clk), .ram_rst(ram_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_byte(req_byte), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_cen(ram_cen),
    .ram_wen(ram_wen), .ram_dout(ram_dout)
  );

  // behavioural RAM, 1-cycle read latency
  logic [15:0] mem [0:(1<<AW)-1];
  initial for (int i = 0; i < (1<<AW); i++) mem[i] = 16'h0;
  initial ram_dout = 16'h0;
  always @(posedge ram_clk) begin
    if (!ram_cen) begin
      ram_dout <= mem[ram_addr];
      if (!ram_wen[1]) mem[ram_addr][15:8] <= ram_din[15:8];
      if (!ram_wen[0]) mem[ram_addr][7:0]  <= ram_din[7:0];
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // scoreboard: pop on every accepted response
  always @(negedge ram_clk) begin
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) chk("sb_unexpected_rsp", 32'd1, 32'd0);
      else begin
        logic [16:0] e;
        e = sb.pop_front();
        chk("rsp_rdata", 32'(rsp_rdata), 32'(e[15:0]));
        chk("rsp_err",   32'(rsp_err),   32'(e[16]));
      end
    end
  end

  // Call at #1 after a rising edge with the DUT in IDLE. Drives one request,
  // checks the RAM strobe in the handshake cycle and the response latency.
  task automatic do_req(input logic we, input logic bt, input logic [AW:0] a,
                        input logic [15:0] wd, input logic stb,
                        input logic [1:0] ewen, input logic [15:0] edin,
                        input logic eerr, input logic [15:0] erd, input int lat);
    req_valid = 1'b1; req_we = we; req_byte = bt; req_addr = a; req_wdata = wd;
    sb.push_back({eerr, erd});
    @(negedge ram_clk);
    chk("req_ready", 32'(req_ready), 32'd1);
    chk("ram_cen",   32'(ram_cen),   32'(!stb));
    chk("ram_wen",   32'(ram_wen),   32'(stb ? ewen : 2'b11));
    chk("ram_addr",  32'(ram_addr),  32'(stb ? a[AW:1] : 6'd0));
    chk("ram_din",   32'(ram_din),   32'(stb ? edin : 16'h0));
    @(posedge ram_clk); #1;
    req_valid = 1'b0;
    for (int i = 1; i <= lat; i++) begin
      @(negedge ram_clk);
      chk("rsp_latency", 32'(rsp_valid), 32'(i == lat));
      chk("cen_idle", 32'(ram_cen), 32'd1);
      if (i < lat) begin @(posedge ram_clk); #1; end
    end
    @(posedge ram_clk); #1;
  endtask

  initial begin
    ram_rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_byte = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;

    // reset: a pending request must not be accepted or strobed
    @(posedge ram_clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 7'h10;
    @(posedge ram_clk);
    @(negedge ram_clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_cen",       32'(ram_cen),   32'd1);
    chk("rst_wen",       32'(ram_wen),   32'd3);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata",     32'(rsp_rdata), 32'd0);
    chk("rst_err",       32'(rsp_err),   32'd0);
    @(posedge ram_clk); #1;
    ram_rst = 1'b0;

    // first cycle out of reset: accepted immediately
    do_req(1, 0, 7'h10, 16'h1234, 1, 2'b00, 16'h1234, 0, 16'h0000, 1);
    do_req(1, 1, 7'h11, 16'h55AB, 1, 2'b01, 16'hAB00, 0, 16'h0000, 1);
    do_req(0, 0, 7'h10, 16'h0000, 1, 2'b11, 16'h0000, 0, 16'hAB34, 2);
    do_req(0, 1, 7'h11, 16'h0000, 1, 2'b11, 16'h0000, 0, 16'h00AB, 2);
    do_req(0, 1, 7'h10, 16'h0000, 1, 2'b11, 16'h0000, 0, 16'h0034, 2);
    // illegal: misaligned word, out of range byte
    do_req(0, 0, 7'h11, 16'h0000, 0, 2'b11, 16'h0000, 1, 16'h0000, 1);
    do_req(1, 1, 7'h50, 16'h00CD, 0, 2'b11, 16'h0000, 1, 16'h0000, 1);
    // even byte write keeps high byte
    do_req(1, 1, 7'h20, 16'hFF5A, 1, 2'b10, 16'h005A, 0, 16'h0000, 1);
    do_req(0, 0, 7'h20, 16'h0000, 1, 2'b11, 16'h0000, 0, 16'h005A, 2);
    // top of memory: last byte legal, MEM_SIZE illegal
    do_req(1, 0, 7'h3E, 16'hBEEF, 1, 2'b00, 16'hBEEF, 0, 16'h0000, 1);
    do_req(0, 1, 7'h3F, 16'h0000, 1, 2'b11, 16'h0000, 0, 16'h00BE, 2);
    do_req(0, 1, 7'h40, 16'h0000, 0, 2'b11, 16'h0000, 1, 16'h0000, 1);

    // backpressure on a word read
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_byte = 1'b0; req_addr = 7'h10;
    sb.push_back({1'b0, 16'hAB34});
    @(posedge ram_clk); #1;          // handshake done, now RD
    req_addr = 7'h3E;                // keep offering; must be refused
    for (int i = 0; i < 5; i++) begin
      @(negedge ram_clk);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_cen",       32'(ram_cen),   32'd1);
      if (i > 0) begin
        chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("bp_rdata",     32'(rsp_rdata), 32'hAB34);
      end
      @(posedge ram_clk); #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge ram_clk);
    @(negedge ram_clk);
    chk("bp_idle_ready", 32'(req_ready), 32'd1);
    chk("bp_rsp_done",   32'(rsp_valid), 32'd0);
    @(posedge ram_clk); #1;

    // reset during RD discards the response
    req_valid = 1'b1; req_we = 1'b0; req_byte = 1'b0; req_addr = 7'h10;
    @(posedge ram_clk); #1;
    req_valid = 1'b0;
    ram_rst = 1'b1;
    @(negedge ram_clk);
    chk("rrd_req_ready", 32'(req_ready), 32'd0);
    @(posedge ram_clk);
    @(negedge ram_clk);
    chk("rrd_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rrd_req_ready2", 32'(req_ready), 32'd0);
    @(posedge ram_clk); #1;
    ram_rst = 1'b0;
    do_req(0, 1, 7'h3E, 16'h0000, 1, 2'b11, 16'h0000, 0, 16'h00EF, 2);

    repeat (2) @(posedge ram_clk);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  // hard bound on run time
  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
